// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
//   - bus widths of the EXE->MEM and MEM->WB buses
//   - mem_inst one-hot bit indices
//   - packed struct views of both buses (field order matches the bus
//     concatenation, MSB first)
//   - load_kind_e plus decode_load(), which turns mem_inst into one load kind
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 165;
  localparam int MS_TO_WS_BUS_WD = 120;
  localparam int MEM_INST_W      = 12;

  localparam int MI_LW  = 0;
  localparam int MI_SW  = 1;
  localparam int MI_LB  = 2;
  localparam int MI_LBU = 3;
  localparam int MI_LH  = 4;
  localparam int MI_LHU = 5;
  localparam int MI_LWL = 6;
  localparam int MI_LWR = 7;

  typedef struct packed {
    logic [31:0]           badvaddr;
    logic [4:0]            mfc0_rd;
    logic                  ex;
    logic [4:0]            exc_code;
    logic                  bd;
    logic                  eret;
    logic [2:0]            sel;
    logic                  mtc0;
    logic                  mfc0;
    logic [31:0]           rt_value;
    logic [MEM_INST_W-1:0] mem_inst;
    logic                  res_from_mem;
    logic                  gr_we;
    logic [4:0]            dest;
    logic [31:0]           alu_result;
    logic [31:0]           pc;
  } es_to_ms_t;

  typedef struct packed {
    logic [4:0]  mfc0_rd;
    logic        ex;
    logic [4:0]  exc_code;
    logic        bd;
    logic        eret;
    logic [2:0]  sel;
    logic        mtc0;
    logic        mfc0;
    logic [31:0] badvaddr;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_t;

  typedef enum logic [2:0] {
    LD_NONE,
    LD_W,
    LD_B,
    LD_BU,
    LD_H,
    LD_HU,
    LD_WL,
    LD_WR
  } load_kind_e;

  // Store bits take precedence so a malformed encoding never aligns data.
  function automatic load_kind_e decode_load(input logic [MEM_INST_W-1:0] mi);
    load_kind_e k;
    k = LD_NONE;
    if (mi[MI_SW] | (|mi[11:8])) k = LD_NONE;
    else if (mi[MI_LW])          k = LD_W;
    else if (mi[MI_LB])          k = LD_B;
    else if (mi[MI_LBU])         k = LD_BU;
    else if (mi[MI_LH])          k = LD_H;
    else if (mi[MI_LHU])         k = LD_HU;
    else if (mi[MI_LWL])         k = LD_WL;
    else if (mi[MI_LWR])         k = LD_WR;
    return k;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Valid/allowin handshake carrying a W-bit payload between two pipeline stages.
//   valid   : producer offers the payload
//   allowin : consumer can accept this cycle
//   bus     : payload
// master = producer side, slave = consumer side.
interface mem_stage_if #(
  parameter int W = 32
);
  logic         valid;
  logic         allowin;
  logic [W-1:0] bus;

  modport master (output valid, output bus, input allowin);
  modport slave  (input valid, input bus, output allowin);
endinterface

// File: rtl/mem_stage_load_align.sv
// Combinational load aligner for the MEM stage.
//   mem_inst : one-hot memory opcode
//   addr     : byte offset alu_result[1:0]
//   rdata    : captured DCache word
//   rt_value : old rt contents, merged in by lwl/lwr
//   value    : aligned, extended load result
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [MEM_INST_W-1:0] mem_inst,
  input  logic [1:0]            addr,
  input  logic [31:0]           rdata,
  input  logic [31:0]           rt_value,
  output logic [31:0]           value
);

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
    logic signed [7:0]  bs;
    logic signed [31:0] ws;
    bs = b;
    ws = 32'(bs);
    return sgn ? $unsigned(ws) : {24'b0, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
    logic signed [15:0] hs;
    logic signed [31:0] ws;
    hs = h;
    ws = 32'(hs);
    return sgn ? $unsigned(ws) : {16'b0, h};
  endfunction

  load_kind_e  kind;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] lwl_val;
  logic [31:0] lwr_val;

  assign kind     = decode_load(mem_inst);
  assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    byte_sel = rdata[7:0];
    lwl_val  = rdata;
    lwr_val  = rdata;
    case (addr)
      2'd0: begin
        byte_sel = rdata[7:0];
        lwl_val  = {rdata[7:0], rt_value[23:0]};
        lwr_val  = rdata;
      end
      2'd1: begin
        byte_sel = rdata[15:8];
        lwl_val  = {rdata[15:0], rt_value[15:0]};
        lwr_val  = {rt_value[31:24], rdata[31:8]};
      end
      2'd2: begin
        byte_sel = rdata[23:16];
        lwl_val  = {rdata[23:0], rt_value[7:0]};
        lwr_val  = {rt_value[31:16], rdata[31:16]};
      end
      default: begin
        byte_sel = rdata[31:24];
        lwl_val  = rdata;
        lwr_val  = {rt_value[31:8], rdata[31:24]};
      end
    endcase
  end

  always_comb begin
    value = rdata;
    case (kind)
      LD_B:    value = ext_byte(byte_sel, 1'b1);
      LD_BU:   value = ext_byte(byte_sel, 1'b0);
      LD_H:    value = ext_half(half_sel, 1'b1);
      LD_HU:   value = ext_half(half_sel, 1'b0);
      LD_WL:   value = lwl_val;
      LD_WR:   value = lwr_val;
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage between EXE and WB.
//   clk, reset            : clock, synchronous active-high reset
//   es_ms (slave)         : EXE->MEM handshake; allowin is ms_allowin
//   ms_ws (master)        : MEM->WB handshake; allowin is ws_allowin
//   data_data_ok/rdata    : DCache completion strobe and read word
//   flush, flush_refill   : pipeline flushes (exception/eret, TLB refill)
//   MEM_dest, MEM_result  : bypass destination (0 when empty) and value
//   ms_ex, ms_inst_eret,
//   ms_inst_mfc0          : status of the valid MEM instruction, for
//                           store suppression and ID interlock
// The DCache word is captured in the same cycle EXE hands the instruction
// over and then held, so a WB stall cannot lose it.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  mem_stage_if.slave        es_ms,
  mem_stage_if.master       ms_ws,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  input  logic              flush,
  input  logic              flush_refill,
  output logic [4:0]        MEM_dest,
  output logic [31:0]       MEM_result,
  output logic              ms_ex,
  output logic              ms_inst_eret,
  output logic              ms_inst_mfc0
);

  es_to_ms_t   es_bus;
  es_to_ms_t   bus_p1;
  logic [31:0] rdata_p1;
  logic        vld_p1;
  logic        ms_allowin;
  logic        handoff;
  logic [31:0] load_value;
  logic [31:0] final_result;
  ms_to_ws_t   ws_bus;

  assign es_bus     = es_to_ms_t'(es_ms.bus);
  assign ms_allowin = !vld_p1 || ms_ws.allowin;
  assign handoff    = es_ms.valid && ms_allowin;
  assign es_ms.allowin = ms_allowin;

  // ---- EXE -> MEM register boundary ----
  always_ff @(posedge clk) begin
    if (reset)                     vld_p1 <= 1'b0;
    else if (flush || flush_refill) vld_p1 <= 1'b0;
    else if (ms_allowin)           vld_p1 <= es_ms.valid;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) bus_p1 <= '0;
    else if (handoff)   bus_p1 <= es_bus;
  end

  // A completion strobe outside a handoff (store ack, stale read) is ignored.
  always_ff @(posedge clk) begin
    if (reset || flush)                rdata_p1 <= '0;
    else if (handoff && data_data_ok)  rdata_p1 <= data_rdata;
  end

  // ---- MEM -> WB combinational output ----
  mem_stage_load_align u_load_align (
    .mem_inst (bus_p1.mem_inst),
    .addr     (bus_p1.alu_result[1:0]),
    .rdata    (rdata_p1),
    .rt_value (bus_p1.rt_value),
    .value    (load_value)
  );

  // mfc0 results are not known here; WB substitutes the CP0 value.
  assign final_result = bus_p1.res_from_mem ? load_value : bus_p1.alu_result;

  always_comb begin
    ws_bus              = '0;
    ws_bus.mfc0_rd      = bus_p1.mfc0_rd;
    ws_bus.ex           = bus_p1.ex;
    ws_bus.exc_code     = bus_p1.exc_code;
    ws_bus.bd           = bus_p1.bd;
    ws_bus.eret         = bus_p1.eret;
    ws_bus.sel          = bus_p1.sel;
    ws_bus.mtc0         = bus_p1.mtc0;
    ws_bus.mfc0         = bus_p1.mfc0;
    ws_bus.badvaddr     = bus_p1.badvaddr;
    ws_bus.gr_we        = bus_p1.gr_we && !bus_p1.ex;
    ws_bus.dest         = bus_p1.dest;
    ws_bus.final_result = final_result;
    ws_bus.pc           = bus_p1.pc;
  end

  assign ms_ws.valid  = vld_p1;
  assign ms_ws.bus    = ws_bus;

  assign MEM_dest     = bus_p1.dest & {5{vld_p1}};
  assign MEM_result   = final_result;
  assign ms_ex        = vld_p1 && bus_p1.ex;
  assign ms_inst_eret = vld_p1 && bus_p1.eret;
  assign ms_inst_mfc0 = vld_p1 && bus_p1.mfc0;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: reset state, load alignment, WB stall
// hold, exception/eret/mfc0 status and flush behaviour.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk;
  logic        reset;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        flush;
  logic        flush_refill;
  logic [4:0]  MEM_dest;
  logic [31:0] MEM_result;
  logic        ms_ex;
  logic        ms_inst_eret;
  logic        ms_inst_mfc0;

  int n_vec;
  int n_err;

  mem_stage_if #(.W(ES_TO_MS_BUS_WD)) es_ms ();
  mem_stage_if #(.W(MS_TO_WS_BUS_WD)) ms_ws ();

  ms_to_ws_t wsb;
  assign wsb = ms_to_ws_t'(ms_ws.bus);

  mem_stage dut (
    .clk          (clk),
    .reset        (reset),
    .es_ms        (es_ms),
    .ms_ws        (ms_ws),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .flush        (flush),
    .flush_refill (flush_refill),
    .MEM_dest     (MEM_dest),
    .MEM_result   (MEM_result),
    .ms_ex        (ms_ex),
    .ms_inst_eret (ms_inst_eret),
    .ms_inst_mfc0 (ms_inst_mfc0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic es_to_ms_t mk(input int mi_bit, input logic rfm, input logic [4:0] dest,
                                   input logic [31:0] alu, input logic [31:0] rt,
                                   input logic ex, input logic eret, input logic mfc0);
    es_to_ms_t b;
    b              = '0;
    if (mi_bit >= 0) b.mem_inst[mi_bit] = 1'b1;
    b.res_from_mem = rfm;
    b.gr_we        = 1'b1;
    b.dest         = dest;
    b.alu_result   = alu;
    b.rt_value     = rt;
    b.ex           = ex;
    b.eret         = eret;
    b.mfc0         = mfc0;
    b.pc           = 32'hBFC0_0100;
    return b;
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    flush = 1'b0;
    flush_refill = 1'b0;
    data_data_ok = 1'b0;
    data_rdata = '0;
    es_ms.valid = 1'b0;
    es_ms.bus = '0;
    ms_ws.allowin = 1'b1;

    // Reset
    repeat (3) step();
    check("rst_valid",   {31'b0, ms_ws.valid},   32'd0);
    check("rst_allowin", {31'b0, es_ms.allowin}, 32'd1);
    check("rst_dest",    {27'b0, MEM_dest},      32'd0);
    check("rst_ex",      {31'b0, ms_ex},         32'd0);
    check("rst_result",  MEM_result,             32'd0);
    reset = 1'b0;

    // lb / lbu at offset 3
    es_ms.valid  = 1'b1;
    data_data_ok = 1'b1;
    data_rdata   = 32'h80FF_1234;
    es_ms.bus    = mk(MI_LB, 1'b1, 5'd5, 32'h1000_0003, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    check("lb_valid",  {31'b0, ms_ws.valid}, 32'd1);
    check("lb_result", MEM_result,           32'hFFFF_FF80);
    check("lb_wsres",  wsb.final_result,     32'hFFFF_FF80);
    check("lb_dest",   {27'b0, MEM_dest},    32'd5);
    check("lb_gr_we",  {31'b0, wsb.gr_we},   32'd1);
    check("lb_pc",     wsb.pc,               32'hBFC0_0100);
    es_ms.bus = mk(MI_LBU, 1'b1, 5'd5, 32'h1000_0003, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    check("lbu_result", MEM_result, 32'h0000_0080);

    // lh at offset 2, lhu at offset 0
    es_ms.bus = mk(MI_LH, 1'b1, 5'd6, 32'h1000_0002, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    check("lh_result", MEM_result, 32'hFFFF_80FF);
    es_ms.bus = mk(MI_LHU, 1'b1, 5'd6, 32'h1000_0000, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    check("lhu_result", MEM_result, 32'h0000_1234);

    // lwl offset 1, lwr offset 2
    data_rdata = 32'h1122_3344;
    es_ms.bus  = mk(MI_LWL, 1'b1, 5'd7, 32'h1000_0001, 32'hAABB_CCDD, 1'b0, 1'b0, 1'b0);
    step();
    check("lwl1_result", MEM_result, 32'h3344_CCDD);
    es_ms.bus = mk(MI_LWR, 1'b1, 5'd7, 32'h1000_0002, 32'hAABB_CCDD, 1'b0, 1'b0, 1'b0);
    step();
    check("lwr2_result", MEM_result, 32'hAABB_1122);

    // lw, then WB stall with new DCache data arriving
    data_rdata = 32'h1234_5678;
    es_ms.bus  = mk(MI_LW, 1'b1, 5'd8, 32'h0000_2000, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    check("lw_result", MEM_result, 32'h1234_5678);
    ms_ws.allowin = 1'b0;
    data_rdata    = 32'hDEAD_BEEF;
    es_ms.bus     = mk(MI_LW, 1'b1, 5'd9, 32'h0000_2004, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_result",  MEM_result,             32'h1234_5678);
      check("stall_allowin", {31'b0, es_ms.allowin}, 32'd0);
      check("stall_dest",    {27'b0, MEM_dest},      32'd8);
    end
    ms_ws.allowin = 1'b1;
    step();
    check("unstall_result", MEM_result,        32'hDEAD_BEEF);
    check("unstall_dest",   {27'b0, MEM_dest}, 32'd9);

    // Completion strobe with no handoff is ignored
    es_ms.valid = 1'b0;
    data_rdata  = 32'h5555_5555;
    step();
    check("stale_valid",  {31'b0, ms_ws.valid}, 32'd0);
    check("stale_result", MEM_result,           32'hDEAD_BEEF);
    check("stale_dest",   {27'b0, MEM_dest},    32'd0);

    // Exception instruction, then flush
    data_data_ok = 1'b0;
    es_ms.valid  = 1'b1;
    es_ms.bus    = mk(-1, 1'b0, 5'd10, 32'h0BAD_F00D, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    check("ex_ms_ex",  {31'b0, ms_ex},        32'd1);
    check("ex_eret",   {31'b0, ms_inst_eret}, 32'd0);
    check("ex_gr_we",  {31'b0, wsb.gr_we},    32'd0);
    check("ex_result", MEM_result,            32'h0BAD_F00D);
    es_ms.valid = 1'b0;
    flush       = 1'b1;
    step();
    flush = 1'b0;
    check("flush_valid",  {31'b0, ms_ws.valid}, 32'd0);
    check("flush_ms_ex",  {31'b0, ms_ex},       32'd0);
    check("flush_result", MEM_result,           32'd0);

    // eret and mfc0 status, then TLB-refill flush
    es_ms.valid = 1'b1;
    es_ms.bus   = mk(-1, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    step();
    check("eret_flag", {31'b0, ms_inst_eret}, 32'd1);
    es_ms.bus = mk(-1, 1'b0, 5'd11, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    step();
    check("mfc0_flag",  {31'b0, ms_inst_mfc0}, 32'd1);
    check("mfc0_gr_we", {31'b0, wsb.gr_we},    32'd1);
    check("mfc0_eret",  {31'b0, ms_inst_eret}, 32'd0);
    es_ms.valid  = 1'b0;
    flush_refill = 1'b1;
    step();
    flush_refill = 1'b0;
    check("refill_valid", {31'b0, ms_ws.valid},  32'd0);
    check("refill_mfc0",  {31'b0, ms_inst_mfc0}, 32'd0);

    // Flush in the same cycle as a valid handoff
    es_ms.valid  = 1'b1;
    data_data_ok = 1'b1;
    data_rdata   = 32'hCAFE_0001;
    es_ms.bus    = mk(MI_LW, 1'b1, 5'd3, 32'h0000_3000, 32'h0, 1'b0, 1'b0, 1'b0);
    flush        = 1'b1;
    step();
    flush        = 1'b0;
    es_ms.valid  = 1'b0;
    data_data_ok = 1'b0;
    check("flushho_valid",  {31'b0, ms_ws.valid}, 32'd0);
    check("flushho_dest",   {27'b0, MEM_dest},    32'd0);
    check("flushho_wsdest", {27'b0, wsb.dest},    32'd0);
    check("flushho_result", MEM_result,           32'd0);
    step();
    check("flushho_valid2", {31'b0, ms_ws.valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
